// File: rtl/mode_pkg.sv
// Shared mode definitions for the front-panel mode selector and the output-mode FSM.
// Also holds the debouncer state encoding used by button_debouncer.
package mode_pkg;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    PWM      = 3'd1,
    R2R      = 3'd2,
    SAWTOOTH = 3'd3,
    BUZZER   = 3'd4,
    CHIRP    = 3'd5
  } mode_e;

  localparam logic [2:0] NUM_MODES = 3'd6;
  localparam logic [2:0] MODE_LAST = 3'd5;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_RELEASE_WAIT
  } db_state_e;

  function automatic logic mode_valid(input logic [2:0] m);
    return m < NUM_MODES;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus debounce FSM; emits a one-cycle press pulse per accepted press.
// Optional auto-repeat while held is compiled in with MODE_SEQ_AUTOREPEAT_EN.
module button_debouncer
  import mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
`ifdef MODE_SEQ_AUTOREPEAT_EN
  ,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 25_000_000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic             level;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_q, press_d;

`ifdef MODE_SEQ_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [REP_W-1:0] rep_q, rep_d;
`endif

  // NOTE: non-blocking assignments so every flop samples its pre-edge value;
  // blocking here would collapse the two synchroniser stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level   = sync_q[1];
  assign cnt_inc = (cnt_q == DB_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // NOTE: every variable gets a default before the case so no path holds a
  // stale value, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
`ifdef MODE_SEQ_AUTOREPEAT_EN
    rep_d   = '0;
`endif
    unique case (state_q)
      DB_IDLE: begin
        cnt_d = '0;
        if (level) begin
          state_d = DB_PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_PRESS_WAIT: begin
        if (!level) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == DB_MAX) begin
          state_d = DB_HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DB_HELD: begin
        if (!level) begin
          state_d = DB_RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
`ifdef MODE_SEQ_AUTOREPEAT_EN
        // Reload lands REPEAT_CYCLES short of the hold threshold for the periodic pulses.
        else if (rep_q == REP_LAST) begin
          press_d = 1'b1;
          rep_d   = REP_RELOAD;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
`else
        else begin
          cnt_d = '0;
        end
`endif
      end
      DB_RELEASE_WAIT: begin
        if (level) begin
          state_d = DB_HELD;
          cnt_d   = '0;
        end else if (cnt_inc == DB_MAX) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef MODE_SEQ_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

  assign press_o = press_q;

endmodule

// File: rtl/mode_sequencer.sv
// Front-panel mode selector: two debounced buttons step a wrapping 0..5 mode index.
// Define MODE_SEQ_AUTOREPEAT_EN to enable auto-repeat while a button is held.
module mode_sequencer
  import mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  output logic [2:0] mode_select,
  output logic       mode_changed
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES == 0 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be in 1..HOLD_CYCLES");
  end

  logic       press_next, press_prev;
  logic [2:0] mode_q, mode_d;
  logic       changed_q, changed_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef MODE_SEQ_AUTOREPEAT_EN
    ,
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
  ) u_next (
    .clk    (clk),
    .rst_n  (reset),
    .btn_i  (btn_next),
    .press_o(press_next)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef MODE_SEQ_AUTOREPEAT_EN
    ,
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
  ) u_prev (
    .clk    (clk),
    .rst_n  (reset),
    .btn_i  (btn_prev),
    .press_o(press_prev)
  );

  // An out-of-range index (upset) recovers to OFF ahead of any button action.
  always_comb begin
    mode_d    = mode_q;
    changed_d = 1'b0;
    if (!mode_valid(mode_q)) begin
      mode_d    = OFF;
      changed_d = 1'b1;
    end else if (press_next && !press_prev) begin
      mode_d    = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
      changed_d = 1'b1;
    end else if (press_prev && !press_next) begin
      mode_d    = (mode_q == 3'd0) ? MODE_LAST : mode_q - 3'd1;
      changed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= OFF;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      changed_q <= changed_d;
    end
  end

  assign mode_select  = mode_q;
  assign mode_changed = changed_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer: vector table plus hand-written corner sequences,
// with a scoreboard queue of expected mode values popped on every mode_changed strobe.
module tb_mode_sequencer;

  logic       clk;
  logic       reset;
  logic       btn_next;
  logic       btn_prev;
  logic [2:0] mode_select;
  logic       mode_changed;

  int n_vec  = 0;
  int n_miss = 0;
  int n_steps = 0;
  int exp_q[$];
  int sb_exp;
  int lat;
  int n0;

`ifdef MODE_SEQ_AUTOREPEAT_EN
  localparam int HOLD_STEPS = 6;
`else
  localparam int HOLD_STEPS = 1;
`endif

  typedef struct {
    bit nxt;
    bit prv;
    int exp_mode;
  } vec_t;

  vec_t vecs[11];

  mode_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .mode_select (mode_select),
    .mode_changed(mode_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expected mode.
  always @(negedge clk) begin
    if (mode_changed) begin
      n_steps++;
      if (exp_q.size() == 0) begin
        check("spurious_step", 1, 0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("step_value", int'(mode_select), sb_exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts edges from the current drive point until the strobe; bounded at 40 cycles.
  task automatic measure(input string name, output int l);
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mode_changed) begin
        l = i;
        break;
      end
    end
    check(name, l, 7);
    @(negedge clk);
    check({name, "_strobe_width"}, int'(mode_changed), 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1};
    vecs[1]  = '{1'b1, 1'b0, 2};
    vecs[2]  = '{1'b1, 1'b0, 3};
    vecs[3]  = '{1'b1, 1'b0, 4};
    vecs[4]  = '{1'b1, 1'b0, 5};
    vecs[5]  = '{1'b1, 1'b0, 0};
    vecs[6]  = '{1'b0, 1'b1, 5};
    vecs[7]  = '{1'b1, 1'b1, 5};
    vecs[8]  = '{1'b0, 1'b1, 4};
    vecs[9]  = '{1'b1, 1'b1, 4};
    vecs[10] = '{1'b0, 1'b1, 3};

    reset    = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;

    // Reset held for 3 cycles, then released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_mode", int'(mode_select), 0);
      check("reset_strobe", int'(mode_changed), 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_mode", int'(mode_select), 0);
      check("post_reset_strobe", int'(mode_changed), 0);
    end

    // Clean press: step lands on edge 7 after the raw edge.
    exp_q.push_back(1);
    btn_next = 1'b1;
    measure("latency_clean", lat);
    check("mode_after_clean", int'(mode_select), 1);
    idle(2);
    btn_next = 1'b0;
    idle(10);

    // Bounce 1,0,1,0 then hold: one step, 7 edges after the final rise.
    exp_q.push_back(2);
    btn_next = 1'b1; @(negedge clk);
    btn_next = 1'b0; @(negedge clk);
    btn_next = 1'b1; @(negedge clk);
    btn_next = 1'b0; @(negedge clk);
    btn_next = 1'b1;
    measure("latency_bounce", lat);
    idle(2);
    btn_next = 1'b0;
    idle(10);
    check("mode_after_bounce", int'(mode_select), 2);
    check("sb_drain_bounce", exp_q.size(), 0);

    reset = 1'b0;
    @(negedge clk);
    check("reset_clears_mode", int'(mode_select), 0);
    reset = 1'b1;
    @(negedge clk);

    // Table: next/prev/both presses, including wrap at both ends.
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].nxt != vecs[v].prv) exp_q.push_back(vecs[v].exp_mode);
      btn_next = vecs[v].nxt;
      btn_prev = vecs[v].prv;
      idle(12);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      idle(10);
      check($sformatf("vec%0d_mode", v), int'(mode_select), vecs[v].exp_mode);
      check($sformatf("vec%0d_sb_drain", v), exp_q.size(), 0);
    end

    // Reset mid-debounce with the button still held: full debounce again after release.
    btn_next = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_abort_mode", int'(mode_select), 0);
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(1);
    reset = 1'b1;
    measure("latency_after_reset", lat);
    idle(2);
    btn_next = 1'b0;
    idle(10);
    check("mode_after_reset_press", int'(mode_select), 1);

    // Long hold: single step, or the auto-repeat train when compiled in.
    n0 = n_steps;
    exp_q.push_back(2);
`ifdef MODE_SEQ_AUTOREPEAT_EN
    exp_q.push_back(3);
    exp_q.push_back(4);
    exp_q.push_back(5);
    exp_q.push_back(0);
    exp_q.push_back(1);
`endif
    btn_next = 1'b1;
    idle(60);
    btn_next = 1'b0;
    idle(15);
    check("hold_step_count", n_steps - n0, HOLD_STEPS);
    check("sb_drain_hold", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
